automaton_sequencer: RTL and testbench
======================================

# automaton_sequencer

Sequences the combinational 1-D cellular-automaton datapath. It holds the current generation in a register, advances it by one generation per accepted row, and streams each row to the downstream frame/line buffer over a valid/ready handshake. Rule and seed are programmed while idle. A `start` pulse produces exactly `ROWS` generations, seed first, then a one-cycle `done` pulse.

## Interface
- `WIDTH`, 80: cells per row (ring; cell 0 and cell WIDTH-1 are neighbours)
- `ROWS`, 60: generations emitted per frame, ≥1
- `IDX_W`, 8: width of the row index; must satisfy 2^IDX_W ≥ ROWS

- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `cfg_we`  in  1  config write; honoured only in IDLE
- `cfg_rule`  in  8  Wolfram rule number
- `cfg_seed`  in  WIDTH  initial generation
- `start`  in  1  begin frame; honoured only in IDLE
- `stop`  in  1  abort frame; honoured only in RUN
- `row_valid`  out  1  `row_data`/`row_idx` valid
- `row_ready`  in  1  downstream accepts the row
- `row_data`  out  WIDTH  current generation
- `row_idx`  out  IDX_W  generation number, 0..ROWS-1
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse at frame completion
- `cur_rule`  out  8  rule register

## Operation
- Registers:
  - `rule_q` (reset 8'd30)
  - `seed_q` (reset: only bit WIDTH/2 set)
  - `gen_q` (reset 0)
  - `idx_q` (reset 0)
  - `state`
- Next generation: `nxt[i] = rule_q[{gen_q[i-1], gen_q[i], gen_q[i+1]}]`, with indices taken modulo WIDTH. Left neighbour is the MSB of the 3-bit index.
- States: IDLE, RUN, DONE.
- IDLE:
  - `cfg_we` loads `rule_q` and `seed_q`.
  - `start` loads `gen_q` with the seed and sets `idx_q` to 0, then goes to RUN.
  - If `cfg_we` and `start` are both high, `gen_q` takes `cfg_seed` directly (bypass) and `rule_q` takes `cfg_rule`.
- RUN:
  - `row_valid`=1, `row_data`=`gen_q`, `row_idx`=`idx_q`.
  - Transfer occurs when `row_valid` and `row_ready` are both high.
  - On a transfer with `idx_q`==ROWS-1: go to DONE; `gen_q` is not updated.
  - On any other transfer: `gen_q` takes `nxt` and `idx_q` increments.
  - With no transfer: `gen_q` and `idx_q` hold, so the data is stable under backpressure.
- `stop` in RUN returns to IDLE at the next edge, with no `done` pulse. `stop` has priority over a same-cycle transfer: the row counts as transferred downstream, but the state still goes to IDLE.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally. `start` and `cfg_we` are ignored in DONE.
- `cfg_we` and `start` are ignored outside IDLE. `stop` is ignored outside RUN.
- `cur_rule` = `rule_q` at all times.
- Reset, from assertion: state IDLE, `row_valid`=0, `busy`=0, `done`=0, `row_idx`=0, `row_data`=0, `cur_rule`=8'd30. Asserting reset mid-frame aborts immediately with no `done`.

## Timing
- All outputs are registered or decoded from `state`; there is no combinational path from `row_ready` to `row_valid`.
- `start` sampled at edge N: `row_valid` is high in cycle N+1 with `row_idx`=0.
- Throughput is one row per cycle when `row_ready` is held high. A full frame takes ROWS cycles in RUN, then 1 cycle in DONE.
- `done` asserts in the cycle after the final transfer. `busy` is low in that same cycle.
- A new `start` is accepted no earlier than 2 cycles after the final transfer, i.e. the first IDLE cycle.
- ROWS=1: the seed row is emitted, then DONE; no generation step occurs.

## Structure
- Shared package holds:
  - the state enum (IDLE/RUN/DONE)
  - reset constants: default rule 8'd30 and the default seed rule (centre bit)
- One sub-module instance: the existing combinational `automaton` (WIDTH parameter passed through), fed by `gen_q` and `rule_q`. The sequencer does not duplicate cell logic.

## Test plan
1. WIDTH=8, ROWS=3, `cfg_we` with rule 30 and seed 8'h10, then `start`, `row_ready`=1 → rows 8'h10, 8'h38, 8'h4C with idx 0, 1, 2 on consecutive cycles, then `done` pulse for 1 cycle, then IDLE.
2. Wrap-around: rule 90, seed 8'h01 → second row 8'h82.
3. Backpressure: test 1 with `row_ready` low for 3 cycles on idx 1 → `row_data` held at 8'h38 and `row_idx` held at 1 throughout; the sequence is otherwise unchanged.
4. `stop` asserted on the idx 1 transfer cycle → IDLE next cycle, no `done`. A subsequent `start` restarts from the seed at idx 0.
5. `cfg_we` and `start` in the same cycle (rule 90, seed 8'h01) → first row 8'h01, then 8'h82. A `cfg_we` issued during RUN leaves `cur_rule` unchanged.
6. Reset asserted asynchronously mid-RUN → `row_valid`, `busy`, `done` all 0 immediately and `cur_rule`=8'd30. After release, `start` emits the default seed (centre bit) as the first row.

Source files
------------

// File: rtl/automaton_sequencer_pkg.sv
// Shared definitions for the cellular-automaton sequencer: the FSM state
// encoding and the reset values of the rule and seed registers.
package automaton_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Rule 30 is the power-up rule.
   localparam logic [7:0] RULE_RST = 8'd30;

   // The power-up seed has exactly one live cell, in the middle of the row.
   function automatic int centre_bit(input int width);
      return width / 2;
   endfunction

endpackage

// File: rtl/automaton_sequencer_automaton.sv
// Combinational 1-D elementary cellular automaton on a ring of WIDTH cells.
// Each new cell is the rule bit selected by {left, self, right}, with the
// left neighbour as the MSB of the 3-bit selector.
module automaton #(
   parameter int WIDTH = 80
) (
   input  logic [WIDTH-1:0] gen,
   input  logic [7:0]       rule,
   output logic [WIDTH-1:0] nxt
);

   // One rule lookup per cell; neighbour indices wrap around the ring.
   always_comb begin
      nxt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         nxt[i] = rule[{gen[(i + WIDTH - 1) % WIDTH], gen[i], gen[(i + 1) % WIDTH]}];
      end
   end

endmodule

// File: rtl/automaton_sequencer.sv
// Frame sequencer for the cellular automaton. Holds the current generation,
// streams ROWS generations (seed first) over a valid/ready handshake and
// pulses done once the last row has been accepted.
//
// Handshake: row_valid is high for the whole RUN state and depends only on
// the state register, never on row_ready. A row transfers on every rising
// edge where row_valid && row_ready; while row_ready is low, row_data and
// row_idx hold their values.
module automaton_sequencer
   import automaton_sequencer_pkg::*;
#(
   parameter int WIDTH = 80,
   parameter int ROWS  = 60,
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [7:0]       cfg_rule,
   input  logic [WIDTH-1:0] cfg_seed,
   input  logic             start,
   input  logic             stop,
   output logic             row_valid,
   input  logic             row_ready,
   output logic [WIDTH-1:0] row_data,
   output logic [IDX_W-1:0] row_idx,
   output logic             busy,
   output logic             done,
   output logic [7:0]       cur_rule
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);
   localparam logic [WIDTH-1:0] SEED_RST = {{(WIDTH-1){1'b0}}, 1'b1} << centre_bit(WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       rule_q;
   logic [WIDTH-1:0] seed_q;
   logic [WIDTH-1:0] gen_q;
   logic [WIDTH-1:0] nxt;
   logic [IDX_W-1:0] idx_q;
   logic             xfer;
   logic             last_row;

   automaton #(
      .WIDTH (WIDTH)
   ) u_automaton (
      .gen  (gen_q),
      .rule (rule_q),
      .nxt  (nxt)
   );

   assign xfer     = (state == ST_RUN) && row_ready;
   assign last_row = (idx_q == LAST_IDX);

   // State register; reset aborts any frame immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode: stop wins over a same-cycle final transfer.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (start) state_nxt = ST_RUN;
         ST_RUN: begin
            if (stop) begin
               state_nxt = ST_IDLE;
            end else if (xfer && last_row) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Configuration, generation and row-index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rule_q <= RULE_RST;
         seed_q <= SEED_RST;
         gen_q  <= '0;
         idx_q  <= '0;
      end else begin
         if (state == ST_IDLE) begin
            if (cfg_we) begin
               rule_q <= cfg_rule;
               seed_q <= cfg_seed;
            end
            if (start) begin
               // A same-cycle config write bypasses seed_q so the new seed
               // is the first row.
               gen_q <= cfg_we ? cfg_seed : seed_q;
               idx_q <= '0;
            end
         end else if (state == ST_RUN) begin
            // The final row is not advanced, so gen_q keeps the last row.
            if (!stop && xfer && !last_row) begin
               gen_q <= nxt;
               idx_q <= idx_q + 1'b1;
            end
         end
      end
   end

   // Outputs come straight from registers or the state decode.
   always_comb begin
      row_valid = (state == ST_RUN);
      busy      = (state == ST_RUN);
      done      = (state == ST_DONE);
      row_data  = gen_q;
      row_idx   = idx_q;
      cur_rule  = rule_q;
   end

endmodule

// File: tb/tb_automaton_sequencer.sv
// Bench for automaton_sequencer on an 8-cell ring with 3-row frames. The
// expected rows come from an arithmetic model of the automaton rule.
module tb_automaton_sequencer;

   localparam int WIDTH = 8;
   localparam int ROWS  = 3;
   localparam int IDX_W = 2;

   logic             clk;
   logic             rst_n;
   logic             cfg_we;
   logic [7:0]       cfg_rule;
   logic [WIDTH-1:0] cfg_seed;
   logic             start;
   logic             stop;
   logic             row_valid;
   logic             row_ready;
   logic [WIDTH-1:0] row_data;
   logic [IDX_W-1:0] row_idx;
   logic             busy;
   logic             done;
   logic [7:0]       cur_rule;

   int n_cmp;
   int n_err;

   // Model of the programmed configuration.
   logic [7:0]       m_rule;
   logic [WIDTH-1:0] m_seed;

   automaton_sequencer #(
      .WIDTH (WIDTH),
      .ROWS  (ROWS),
      .IDX_W (IDX_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_rule  (cfg_rule),
      .cfg_seed  (cfg_seed),
      .start     (start),
      .stop      (stop),
      .row_valid (row_valid),
      .row_ready (row_ready),
      .row_data  (row_data),
      .row_idx   (row_idx),
      .busy      (busy),
      .done      (done),
      .cur_rule  (cur_rule)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: one automaton generation, from the rule-number definition.
   function automatic logic [WIDTH-1:0] model_next(input logic [WIDTH-1:0] g, input logic [7:0] rule);
      logic [WIDTH-1:0] r;
      int l, c, rr, sel;
      r = '0;
      for (int i = 0; i < WIDTH; i++) begin
         l   = int'((g >> ((i + WIDTH - 1) % WIDTH)) & 1);
         c   = int'((g >> i) & 1);
         rr  = int'((g >> ((i + 1) % WIDTH)) & 1);
         sel = 4 * l + 2 * c + rr;
         r[i] = ((rule >> sel) & 8'd1) != 0;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".valid"}, 32'(row_valid), 32'd0);
      chk({tag, ".busy"},  32'(busy),      32'd0);
      chk({tag, ".done"},  32'(done),      32'd0);
      chk({tag, ".rule"},  32'(cur_rule),  32'(m_rule));
   endtask

   task automatic cfg_write(input logic [7:0] rule, input logic [WIDTH-1:0] seed);
      cfg_we = 1'b1; cfg_rule = rule; cfg_seed = seed;
      step();
      cfg_we = 1'b0;
      m_rule = rule; m_seed = seed;
      chk("cfg.rule", 32'(cur_rule), 32'(rule));
   endtask

   // Start a frame, optionally with a same-cycle config write.
   task automatic do_start(input bit with_cfg, input logic [7:0] rule, input logic [WIDTH-1:0] seed);
      cfg_we = with_cfg; cfg_rule = rule; cfg_seed = seed; start = 1'b1;
      step();
      cfg_we = 1'b0; start = 1'b0;
      if (with_cfg) begin
         m_rule = rule; m_seed = seed;
      end
   endtask

   // Consume one frame cycle by cycle. stall_idx/stall_n hold ready low on a
   // row, stop_idx aborts on that row's transfer, rnd randomises ready, and
   // noise drives cfg_we/start garbage that must be ignored outside IDLE.
   task automatic run_frame(input int stall_idx, input int stall_n, input int stop_idx,
                            input bit rnd, input bit noise, input string tag);
      logic [WIDTH-1:0] exp_row;
      int k, stalls, budget;
      bit rdy, stopping, finished;
      exp_row = m_seed; k = 0; stalls = 0; budget = 100; finished = 0;
      while (!finished && budget > 0) begin
         budget--;
         chk({tag, ".valid"}, 32'(row_valid), 32'd1);
         chk({tag, ".busy"},  32'(busy),      32'd1);
         chk({tag, ".done"},  32'(done),      32'd0);
         chk({tag, ".idx"},   32'(row_idx),   32'(k));
         chk({tag, ".data"},  32'(row_data),  32'(exp_row));
         chk({tag, ".rule"},  32'(cur_rule),  32'(m_rule));
         if (rnd) rdy = ($urandom_range(0, 3) != 0);
         else if (k == stall_idx && stalls < stall_n) rdy = 1'b0;
         else rdy = 1'b1;
         if (!rdy) stalls++;
         stopping  = (k == stop_idx) && rdy;
         row_ready = rdy;
         stop      = stopping;
         if (noise) begin
            cfg_we   = 1'($urandom_range(0, 1));
            start    = 1'($urandom_range(0, 1));
            cfg_rule = 8'($urandom);
            cfg_seed = WIDTH'($urandom);
         end
         step();
         stop = 1'b0;
         if (stopping) begin
            cfg_we = 1'b0; start = 1'b0;
            chk_idle({tag, ".stop"});
            finished = 1;
         end else if (rdy && k == ROWS - 1) begin
            chk({tag, ".done_pulse"}, 32'(done),      32'd1);
            chk({tag, ".done_busy"},  32'(busy),      32'd0);
            chk({tag, ".done_valid"}, 32'(row_valid), 32'd0);
            step();
            cfg_we = 1'b0; start = 1'b0;
            chk_idle({tag, ".after_done"});
            finished = 1;
         end else if (rdy) begin
            exp_row = model_next(exp_row, m_rule);
            k++;
         end
      end
      row_ready = 1'b1;
      if (!finished) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s.timeout: observed no frame end expected end within 100 cycles", tag);
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      rst_n = 1'b0; cfg_we = 1'b0; cfg_rule = '0; cfg_seed = '0;
      start = 1'b0; stop = 1'b0; row_ready = 1'b1;
      m_rule = 8'd30; m_seed = 8'h10;

      // Reset values.
      #12;
      chk_idle("reset");
      chk("reset.idx",  32'(row_idx),  32'd0);
      chk("reset.data", 32'(row_data), 32'd0);
      rst_n = 1'b1;
      step();

      // Rule 30 from a single cell: 10, 38, 4C.
      cfg_write(8'd30, 8'h10);
      do_start(0, '0, '0);
      chk("t1.row0", 32'(row_data), 32'h10);
      run_frame(-1, 0, -1, 0, 0, "t1");

      // Ring wrap with rule 90: 01 -> 82.
      cfg_write(8'd90, 8'h01);
      do_start(0, '0, '0);
      step();
      chk("t2.row1", 32'(row_data), 32'h82);
      chk("t2.idx1", 32'(row_idx),  32'd1);
      step();
      step();
      step();
      chk_idle("t2.end");

      // Backpressure on idx 1 for three cycles.
      cfg_write(8'd30, 8'h10);
      do_start(0, '0, '0);
      run_frame(1, 3, -1, 0, 0, "t3");

      // Stop on the idx 1 transfer, then a restart from the seed.
      do_start(0, '0, '0);
      run_frame(-1, 0, 1, 0, 0, "t4a");
      do_start(0, '0, '0);
      run_frame(-1, 0, -1, 0, 0, "t4b");

      // Same-cycle config and start, with config noise during RUN/DONE.
      do_start(1, 8'd90, 8'h01);
      chk("t5.row0", 32'(row_data), 32'h01);
      run_frame(-1, 0, -1, 0, 1, "t5");

      // Random rules, seeds and ready patterns.
      for (int f = 0; f < 8; f++) begin
         do_start(1, 8'($urandom), WIDTH'($urandom));
         run_frame(-1, 0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ROWS - 1)) : -1,
                   1, 1, "rnd");
      end

      // Asynchronous reset in the middle of a frame.
      cfg_write(8'd90, 8'h01);
      do_start(0, '0, '0);
      step();
      #3;
      rst_n = 1'b0;
      #1;
      m_rule = 8'd30; m_seed = 8'h10;
      chk_idle("t6.reset");
      chk("t6.data", 32'(row_data), 32'd0);
      chk("t6.idx",  32'(row_idx),  32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      do_start(0, '0, '0);
      chk("t6.row0", 32'(row_data), 32'h10);
      run_frame(-1, 0, -1, 0, 0, "t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
